// File: rtl/cpu_ctrl_pkg.sv
// Shared control-path definitions for the branch sequencer:
// one-hot control-step states, C2 condition codes and the default branch opcode.
package cpu_ctrl_pkg;

  typedef enum logic [7:0] {
    S_IDLE = 8'b0000_0001,
    S_T0   = 8'b0000_0010,
    S_T1   = 8'b0000_0100,
    S_T2   = 8'b0000_1000,
    S_T3   = 8'b0001_0000,
    S_T4   = 8'b0010_0000,
    S_T5   = 8'b0100_0000,
    S_T6   = 8'b1000_0000
  } state_e;

  // Branch condition codes held in the IR C2 field
  localparam logic [1:0] CC_ZR = 2'b00;  // taken when bus == 0
  localparam logic [1:0] CC_NZ = 2'b01;  // taken when bus != 0
  localparam logic [1:0] CC_PL = 2'b10;  // taken when bus is non-negative
  localparam logic [1:0] CC_MI = 2'b11;  // taken when bus is negative

  localparam logic [4:0] BR_OPCODE_DEF = 5'b10010;

endpackage

// File: rtl/con_eval.sv
// Combinational branch-condition evaluator: C2 code plus bus value -> cond.
module con_eval
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [1:0]        c2,
  input  logic [DATA_W-1:0] bus,
  output logic              cond
);

  // Decode the condition code against the bus contents
  always_comb begin
    cond = 1'b0;
    case (c2)
      CC_ZR:   cond = (bus == '0);
      CC_NZ:   cond = (bus != '0);
      CC_PL:   cond = ~bus[DATA_W-1];
      CC_MI:   cond = bus[DATA_W-1];
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_sequencer.sv
// Hardwired control-step sequencer for the branch instruction class.
// Optional macro BRANCH_STATS_EN adds saturating taken / not-taken counters.
module branch_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned          DATA_W    = 32,
  parameter int unsigned          OPC_W     = 5,
  parameter logic [OPC_W-1:0]     BR_OPCODE = OPC_W'(BR_OPCODE_DEF),
  parameter int unsigned          C2_LSB    = 19
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic              Run,
  input  logic              Mem_ready,
  input  logic [DATA_W-1:0] IR,
  input  logic [DATA_W-1:0] bus,
  output logic              PCout,
  output logic              MARin,
  output logic              ZLowIn,
  output logic              ZLowout,
  output logic              PCin,
  output logic              Read,
  output logic              MDRin,
  output logic              IncPC,
  output logic              MDRout,
  output logic              IRin,
  output logic              GRA,
  output logic              Rout,
  output logic              CONin,
  output logic              Yin,
  output logic              Cout,
  output logic              CON,
  output logic              Done,
  output logic              Illegal
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]       Taken_cnt,
  output logic [15:0]       NotTaken_cnt
`endif
);

  state_e state_q, state_d;
  logic   con_q, con_d;
  logic   t1_hold_q, t1_hold_d;   // set while T1 is waiting beyond its first cycle

  logic [OPC_W-1:0] opcode;
  logic [1:0]       c2;
  logic             opc_match;
  logic             cond;
  logic             unused_ir;

  assign opcode    = IR[DATA_W-1 -: OPC_W];
  assign c2        = IR[C2_LSB +: 2];
  assign opc_match = (opcode == BR_OPCODE);
  assign unused_ir = ^IR;
  assign CON       = con_q;

  con_eval #(.DATA_W(DATA_W)) u_con_eval (
    .c2   (c2),
    .bus  (bus),
    .cond (cond)
  );

  // State, condition flag and T1-wait flag registers
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q   <= S_IDLE;
      con_q     <= 1'b0;
      t1_hold_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      con_q     <= con_d;
      t1_hold_q <= t1_hold_d;
    end
  end

  // Next-state and CON update; Run is only looked at in IDLE, T3 exit and T6
  always_comb begin
    state_d   = state_q;
    con_d     = con_q;
    t1_hold_d = 1'b0;
    case (state_q)
      S_IDLE: if (Run) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1: begin
        if (Mem_ready) state_d = S_T2;
        else           t1_hold_d = 1'b1;
      end
      S_T2:   state_d = S_T3;
      S_T3: begin
        if (opc_match) con_d = cond;
        if (opc_match && cond) state_d = S_T4;
        else                   state_d = Run ? S_T0 : S_IDLE;
      end
      S_T4:   state_d = S_T5;
      S_T5:   state_d = S_T6;
      S_T6:   state_d = Run ? S_T0 : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobe decode from registered state; T3 is additionally gated by the opcode
  always_comb begin
    PCout   = 1'b0;
    MARin   = 1'b0;
    ZLowIn  = 1'b0;
    ZLowout = 1'b0;
    PCin    = 1'b0;
    Read    = 1'b0;
    MDRin   = 1'b0;
    IncPC   = 1'b0;
    MDRout  = 1'b0;
    IRin    = 1'b0;
    GRA     = 1'b0;
    Rout    = 1'b0;
    CONin   = 1'b0;
    Yin     = 1'b0;
    Cout    = 1'b0;
    Done    = 1'b0;
    Illegal = 1'b0;
    case (state_q)
      S_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        ZLowIn = 1'b1;
      end
      S_T1: begin
        ZLowout = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        PCin    = ~t1_hold_q;
        IncPC   = ~t1_hold_q;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        if (opc_match) begin
          GRA   = 1'b1;
          Rout  = 1'b1;
          CONin = 1'b1;
          Done  = ~cond;
        end else begin
          Illegal = 1'b1;
          Done    = 1'b1;
        end
      end
      S_T4: begin
        PCout = 1'b1;
        Yin   = 1'b1;
      end
      S_T5: begin
        Cout   = 1'b1;
        ZLowIn = 1'b1;
      end
      S_T6: begin
        ZLowout = 1'b1;
        PCin    = 1'b1;
        Done    = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt_q, taken_cnt_d;
  logic [15:0] nottaken_cnt_q, nottaken_cnt_d;

  assign Taken_cnt    = taken_cnt_q;
  assign NotTaken_cnt = nottaken_cnt_q;

  // Saturating retire counters for taken and legal not-taken branches
  always_comb begin
    taken_cnt_d    = taken_cnt_q;
    nottaken_cnt_d = nottaken_cnt_q;
    if (state_q == S_T6 && taken_cnt_q != '1)
      taken_cnt_d = taken_cnt_q + 16'd1;
    if (state_q == S_T3 && opc_match && !cond && nottaken_cnt_q != '1)
      nottaken_cnt_d = nottaken_cnt_q + 16'd1;
  end

  // Counter registers
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      taken_cnt_q    <= '0;
      nottaken_cnt_q <= '0;
    end else begin
      taken_cnt_q    <= taken_cnt_d;
      nottaken_cnt_q <= nottaken_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: directed cases plus randomized
// instructions checked cycle by cycle against a timeline model.
module tb_branch_sequencer;

  logic        Clock = 1'b0;
  logic        Clear;
  logic        Run;
  logic        Mem_ready;
  logic [31:0] IR;
  logic [31:0] bus;
  logic PCout, MARin, ZLowIn, ZLowout, PCin, Read, MDRin, IncPC, MDRout, IRin;
  logic GRA, Rout, CONin, Yin, Cout, CON, Done, Illegal;
`ifdef BRANCH_STATS_EN
  logic [15:0] Taken_cnt, NotTaken_cnt;
`endif

  always #5 Clock = ~Clock;

  branch_sequencer #(
    .DATA_W    (32),
    .OPC_W     (5),
    .BR_OPCODE (5'b10010),
    .C2_LSB    (19)
  ) dut (
    .Clock     (Clock),
    .Clear     (Clear),
    .Run       (Run),
    .Mem_ready (Mem_ready),
    .IR        (IR),
    .bus       (bus),
    .PCout     (PCout),
    .MARin     (MARin),
    .ZLowIn    (ZLowIn),
    .ZLowout   (ZLowout),
    .PCin      (PCin),
    .Read      (Read),
    .MDRin     (MDRin),
    .IncPC     (IncPC),
    .MDRout    (MDRout),
    .IRin      (IRin),
    .GRA       (GRA),
    .Rout      (Rout),
    .CONin     (CONin),
    .Yin       (Yin),
    .Cout      (Cout),
    .CON       (CON),
    .Done      (Done),
    .Illegal   (Illegal)
`ifdef BRANCH_STATS_EN
    ,
    .Taken_cnt    (Taken_cnt),
    .NotTaken_cnt (NotTaken_cnt)
`endif
  );

  // Output word: {PCout,MARin,ZLowIn,ZLowout,PCin,Read,MDRin,IncPC,MDRout,
  //               IRin,GRA,Rout,CONin,Yin,Cout,CON,Done,Illegal}
  localparam logic [17:0] M_PCOUT   = 18'h1 << 17;
  localparam logic [17:0] M_MARIN   = 18'h1 << 16;
  localparam logic [17:0] M_ZLOWIN  = 18'h1 << 15;
  localparam logic [17:0] M_ZLOWOUT = 18'h1 << 14;
  localparam logic [17:0] M_PCIN    = 18'h1 << 13;
  localparam logic [17:0] M_READ    = 18'h1 << 12;
  localparam logic [17:0] M_MDRIN   = 18'h1 << 11;
  localparam logic [17:0] M_INCPC   = 18'h1 << 10;
  localparam logic [17:0] M_MDROUT  = 18'h1 << 9;
  localparam logic [17:0] M_IRIN    = 18'h1 << 8;
  localparam logic [17:0] M_GRA     = 18'h1 << 7;
  localparam logic [17:0] M_ROUT    = 18'h1 << 6;
  localparam logic [17:0] M_CONIN   = 18'h1 << 5;
  localparam logic [17:0] M_YIN     = 18'h1 << 4;
  localparam logic [17:0] M_COUT    = 18'h1 << 3;
  localparam logic [17:0] M_CON     = 18'h1 << 2;
  localparam logic [17:0] M_DONE    = 18'h1 << 1;
  localparam logic [17:0] M_ILLEGAL = 18'h1;

  localparam logic [4:0] BR = 5'b10010;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model state
  bit          m_con = 1'b0;
  int unsigned m_taken = 0;
  int unsigned m_nottaken = 0;

  logic [17:0] dut_vec;
  assign dut_vec = {PCout, MARin, ZLowIn, ZLowout, PCin, Read, MDRin, IncPC, MDRout,
                    IRin, GRA, Rout, CONin, Yin, Cout, CON, Done, Illegal};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_cond(input logic [1:0] c2, input logic [31:0] b);
    case (c2)
      2'd0:    return b == 32'd0;
      2'd1:    return b != 32'd0;
      2'd2:    return b[31] == 1'b0;
      default: return b[31] == 1'b1;
    endcase
  endfunction

  function automatic logic [17:0] con_bit();
    return m_con ? M_CON : 18'h0;
  endfunction

  // One clock cycle: inputs already driven; compare at the falling edge
  task automatic run_cycle(input logic [17:0] exp, input string tag);
    @(negedge Clock);
    check_eq(tag, 32'(dut_vec), 32'(exp));
    check_eq("bus_drivers_exclusive",
             32'($countones({PCout, ZLowout, MDRout, Rout, Cout}) <= 1), 32'd1);
    @(posedge Clock);
    #1;
  endtask

  // One instruction starting at its T0 cycle. w = Mem_ready=0 cycles in T1.
  // run_after = Run value at exit; gap = idle cycles when run_after is 0.
  task automatic do_instr(input logic [4:0] opc, input logic [1:0] c2, input logic [31:0] busv,
                          input int unsigned w, input bit run_after, input int unsigned gap);
    logic [31:0] ir;
    bit legal, taken;
    ir = $urandom;
    ir[31:27] = opc;
    ir[20:19] = c2;
    IR  = ir;
    bus = busv;
    legal = (opc == BR);
    taken = legal && ref_cond(c2, busv);

    Run = 1'($urandom); Mem_ready = 1'($urandom);
    run_cycle(M_PCOUT | M_MARIN | M_ZLOWIN | con_bit(), "T0");
    Run = 1'($urandom); Mem_ready = (w == 0);
    run_cycle(M_ZLOWOUT | M_PCIN | M_INCPC | M_READ | M_MDRIN | con_bit(), "T1_first");
    for (int unsigned k = 1; k <= w; k++) begin
      Run = 1'($urandom); Mem_ready = (k == w);
      run_cycle(M_ZLOWOUT | M_READ | M_MDRIN | con_bit(), "T1_wait");
    end
    Run = 1'($urandom); Mem_ready = 1'($urandom);
    run_cycle(M_MDROUT | M_IRIN | con_bit(), "T2");
    if (taken) begin
      Run = 1'($urandom);
      run_cycle(M_GRA | M_ROUT | M_CONIN | con_bit(), "T3_taken");
      m_con = 1'b1;
      Run = 1'($urandom);
      run_cycle(M_PCOUT | M_YIN | con_bit(), "T4");
      Run = 1'($urandom);
      run_cycle(M_COUT | M_ZLOWIN | con_bit(), "T5");
      Run = run_after;
      run_cycle(M_ZLOWOUT | M_PCIN | M_DONE | con_bit(), "T6");
      m_taken++;
    end else if (legal) begin
      Run = run_after;
      run_cycle(M_GRA | M_ROUT | M_CONIN | M_DONE | con_bit(), "T3_not_taken");
      m_con = 1'b0;
      m_nottaken++;
    end else begin
      Run = run_after;
      run_cycle(M_DONE | M_ILLEGAL | con_bit(), "T3_illegal");
    end
    if (!run_after) begin
      for (int unsigned g = 0; g < gap; g++) begin
        Run = (g == gap - 1);
        Mem_ready = 1'($urandom);
        run_cycle(con_bit(), "IDLE");
      end
    end
  endtask

  // Taken branch aborted by Clear in the middle of T5; leaves the DUT at T0
  task automatic abort_in_t5();
    IR = $urandom; IR[31:27] = BR; IR[20:19] = 2'b00; bus = 32'd0;
    Mem_ready = 1'b1; Run = 1'b1;
    run_cycle(M_PCOUT | M_MARIN | M_ZLOWIN | con_bit(), "abort_T0");
    run_cycle(M_ZLOWOUT | M_PCIN | M_INCPC | M_READ | M_MDRIN | con_bit(), "abort_T1");
    run_cycle(M_MDROUT | M_IRIN | con_bit(), "abort_T2");
    run_cycle(M_GRA | M_ROUT | M_CONIN | con_bit(), "abort_T3");
    m_con = 1'b1;
    run_cycle(M_PCOUT | M_YIN | con_bit(), "abort_T4");
    #2;
    Clear = 1'b0;
    #1;
    check_eq("abort_outputs_zero", 32'(dut_vec), 32'd0);
    m_con = 1'b0; m_taken = 0; m_nottaken = 0;
`ifdef BRANCH_STATS_EN
    check_eq("abort_taken_cnt", 32'(Taken_cnt), 32'd0);
    check_eq("abort_nottaken_cnt", 32'(NotTaken_cnt), 32'd0);
`endif
    @(posedge Clock);
    #1;
    Clear = 1'b1; Run = 1'b0;
    run_cycle(18'h0, "abort_idle");
    Run = 1'b1;
    run_cycle(18'h0, "abort_idle_run");
  endtask

  initial begin
    Clear = 1'b0; Run = 1'b1; Mem_ready = 1'b1; IR = '0; bus = '0;
    #12;
    check_eq("reset_outputs", 32'(dut_vec), 32'd0);
    @(posedge Clock);
    #1;
    Clear = 1'b1; Run = 1'b0;
    run_cycle(18'h0, "idle_after_reset");
    Run = 1'b1;
    run_cycle(18'h0, "idle_run");

    // Directed cases
    do_instr(BR, 2'b00, 32'd0,         0, 1'b1, 1);  // taken, 7 cycles
    do_instr(BR, 2'b00, 32'h5,         0, 1'b1, 1);  // not taken, next T0 at once
    do_instr(BR, 2'b11, 32'h8000_0000, 0, 1'b1, 1);  // MI taken
    do_instr(BR, 2'b10, 32'h8000_0000, 0, 1'b1, 1);  // PL not taken
    do_instr(BR, 2'b01, 32'h1,         3, 1'b0, 2);  // memory wait, 10 cycles
    do_instr(5'b00011, 2'b00, 32'd0,   0, 1'b1, 1);  // illegal opcode
    do_instr(BR, 2'b01, 32'h7,         0, 1'b1, 1);  // sets CON before abort
    abort_in_t5();

    // Counter scenario after reset: 3 taken, 2 not taken
    do_instr(BR, 2'b00, 32'd0,         0, 1'b1, 1);
    do_instr(BR, 2'b01, 32'd0,         1, 1'b1, 1);
    do_instr(BR, 2'b11, 32'hF000_0000, 0, 1'b1, 1);
    do_instr(BR, 2'b10, 32'h8000_0001, 2, 1'b1, 1);
    do_instr(BR, 2'b01, 32'h10,        0, 1'b0, 1);
`ifdef BRANCH_STATS_EN
    check_eq("taken_cnt_3", 32'(Taken_cnt), 32'(m_taken));
    check_eq("nottaken_cnt_2", 32'(NotTaken_cnt), 32'(m_nottaken));
`endif

    // Randomized instructions
    for (int unsigned n = 0; n < 150; n++) begin
      logic [4:0]  opc;
      logic [31:0] bv;
      opc = ($urandom_range(0, 3) == 0) ? 5'($urandom) : BR;
      case ($urandom_range(0, 3))
        0:       bv = 32'd0;
        1:       bv = 32'h8000_0000 | 32'($urandom);
        2:       bv = 32'($urandom_range(1, 255));
        default: bv = $urandom;
      endcase
      do_instr(opc, 2'($urandom), bv, $urandom_range(0, 3),
               $urandom_range(0, 2) != 0, $urandom_range(1, 3));
    end
`ifdef BRANCH_STATS_EN
    check_eq("taken_cnt_final", 32'(Taken_cnt), 32'(m_taken));
    check_eq("nottaken_cnt_final", 32'(NotTaken_cnt), 32'(m_nottaken));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
